// File: rtl/ofdm_cp_strip.sv
// ofdm_cp_strip
// Removes the cyclic prefix from a stream of OFDM symbols. The NFFT-sample
// body of each symbol is stored in one of two ping-pong banks, and a full
// bank is replayed to the FFT as one contiguous burst of NFFT samples.
//
// Parameters:
//   SIZE_BUFFER   log2(NFFT), where NFFT is the number of body samples per symbol
//   DATA_FFT_SIZE I/Q sample width (two's complement, passed bit-exact)
//   CP_LEN        cyclic-prefix samples discarded per symbol (0..NFFT-1)
// Ports:
//   clk             rising-edge clock
//   reset           asynchronous reset, active low
//   valid_in        input sample qualifier
//   sym_start       first (CP) sample of a symbol, meaningful with valid_in
//   data_in_i/q     input sample
//   flag_wayt_data  FFT ready for a new NFFT burst
//   valid           burst valid to the FFT
//   data_out_i/q    body sample to the FFT, zero while valid is low
//   overflow        one-cycle pulse: symbol dropped, no free bank
//   sym_abort       one-cycle pulse: partial symbol discarded on a new sym_start
module ofdm_cp_strip #(
  parameter int SIZE_BUFFER   = 8,
  parameter int DATA_FFT_SIZE = 16,
  parameter int CP_LEN        = 32
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     valid_in,
  input  logic                     sym_start,
  input  logic [DATA_FFT_SIZE-1:0] data_in_i,
  input  logic [DATA_FFT_SIZE-1:0] data_in_q,
  input  logic                     flag_wayt_data,
  output logic                     valid,
  output logic [DATA_FFT_SIZE-1:0] data_out_i,
  output logic [DATA_FFT_SIZE-1:0] data_out_q,
  output logic                     overflow,
  output logic                     sym_abort
);

  localparam int NFFT = 1 << SIZE_BUFFER;
  localparam logic [SIZE_BUFFER-1:0] ADDR_ONE  = SIZE_BUFFER'(1);
  localparam logic [SIZE_BUFFER-1:0] ADDR_LAST = SIZE_BUFFER'(NFFT - 1);
  localparam logic [SIZE_BUFFER-1:0] ADDR_PRE  = SIZE_BUFFER'(NFFT - 2);
  // Count value of the last CP sample; only used when CP_LEN >= 2.
  localparam logic [SIZE_BUFFER-1:0] CP_LAST   = SIZE_BUFFER'(CP_LEN - 1);

  typedef enum logic [1:0] {W_IDLE, W_CP, W_BODY} w_state_t;
  typedef enum logic {R_IDLE, R_BURST} r_state_t;

  // Both banks share one array; the bank number is the address MSB.
  logic [DATA_FFT_SIZE-1:0] mem_i [0:2*NFFT-1];
  logic [DATA_FFT_SIZE-1:0] mem_q [0:2*NFFT-1];

  w_state_t                 w_state, w_state_n;
  logic [SIZE_BUFFER-1:0]   w_cnt, w_cnt_n;
  logic                     w_bank, w_bank_n;
  logic                     we;
  logic [SIZE_BUFFER-1:0]   waddr;
  logic                     set_full;
  logic                     ovf_n, abort_n;

  r_state_t                 r_state, r_state_n;
  logic                     r_bank, r_bank_n;
  logic                     rd_en, rd_en_n;
  logic [SIZE_BUFFER-1:0]   rd_addr, rd_addr_n;
  logic                     rd_bank, rd_bank_n;
  logic                     rel;

  logic [1:0]               full;
  logic                     start;
  logic                     bank_free;

  assign start = valid_in && sym_start;
  // A bank released by the reader on this very edge counts as free.
  assign bank_free = !full[w_bank] || (rel && (r_bank == w_bank));

  // Write FSM next-state: CP samples are counted and dropped, body samples
  // are written; a sym_start always restarts the symbol on the current bank.
  always_comb begin
    logic restart;
    w_state_n = w_state;
    w_cnt_n   = w_cnt;
    w_bank_n  = w_bank;
    we        = 1'b0;
    waddr     = w_cnt;
    set_full  = 1'b0;
    ovf_n     = 1'b0;
    abort_n   = 1'b0;
    restart   = 1'b0;
    case (w_state)
      W_IDLE: begin
        if (start) begin
          if (bank_free) restart = 1'b1;
          else           ovf_n   = 1'b1;
        end
      end
      W_CP: begin
        if (start) begin
          abort_n = 1'b1;
          restart = 1'b1;
        end else if (valid_in) begin
          if (w_cnt == CP_LAST) begin
            w_state_n = W_BODY;
            w_cnt_n   = '0;
          end else begin
            w_cnt_n = w_cnt + ADDR_ONE;
          end
        end
      end
      W_BODY: begin
        if (start) begin
          abort_n = 1'b1;
          restart = 1'b1;
        end else if (valid_in) begin
          we    = 1'b1;
          waddr = w_cnt;
          if (w_cnt == ADDR_LAST) begin
            set_full  = 1'b1;
            w_bank_n  = ~w_bank;
            w_state_n = W_IDLE;
            w_cnt_n   = '0;
          end else begin
            w_cnt_n = w_cnt + ADDR_ONE;
          end
        end
      end
      default: w_state_n = W_IDLE;
    endcase
    // The start sample is CP sample 1, or body sample 0 when there is no CP.
    if (restart) begin
      if (CP_LEN == 0) begin
        we        = 1'b1;
        waddr     = '0;
        w_cnt_n   = ADDR_ONE;
        w_state_n = W_BODY;
      end else if (CP_LEN == 1) begin
        w_cnt_n   = '0;
        w_state_n = W_BODY;
      end else begin
        w_cnt_n   = ADDR_ONE;
        w_state_n = W_CP;
      end
    end
  end

  // Read FSM next-state: one address is issued per cycle for NFFT cycles;
  // the bank is released on the edge that issues the last address.
  always_comb begin
    r_state_n = r_state;
    r_bank_n  = r_bank;
    rd_en_n   = 1'b0;
    rd_addr_n = rd_addr;
    rd_bank_n = rd_bank;
    rel       = 1'b0;
    case (r_state)
      R_IDLE: begin
        if (full[r_bank] && flag_wayt_data) begin
          r_state_n = R_BURST;
          rd_en_n   = 1'b1;
          rd_addr_n = '0;
          rd_bank_n = r_bank;
        end
      end
      R_BURST: begin
        rd_en_n   = 1'b1;
        rd_addr_n = rd_addr + ADDR_ONE;
        if (rd_addr == ADDR_PRE) begin
          rel       = 1'b1;
          r_bank_n  = ~r_bank;
          r_state_n = R_IDLE;
        end
      end
      default: r_state_n = R_IDLE;
    endcase
  end

  // Buffer RAM write port; contents are never reset because every output
  // sample is read only from a bank whose full flag was set by a write.
  always_ff @(posedge clk) begin
    if (we) begin
      mem_i[{w_bank, waddr}] <= data_in_i;
      mem_q[{w_bank, waddr}] <= data_in_q;
    end
  end

  // Control state, full flags and registered outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      w_state    <= W_IDLE;
      w_cnt      <= '0;
      w_bank     <= 1'b0;
      r_state    <= R_IDLE;
      r_bank     <= 1'b0;
      rd_en      <= 1'b0;
      rd_addr    <= '0;
      rd_bank    <= 1'b0;
      full       <= 2'b00;
      valid      <= 1'b0;
      data_out_i <= '0;
      data_out_q <= '0;
      overflow   <= 1'b0;
      sym_abort  <= 1'b0;
    end else begin
      w_state   <= w_state_n;
      w_cnt     <= w_cnt_n;
      w_bank    <= w_bank_n;
      r_state   <= r_state_n;
      r_bank    <= r_bank_n;
      rd_en     <= rd_en_n;
      rd_addr   <= rd_addr_n;
      rd_bank   <= rd_bank_n;
      full      <= (full & ~((rel ? 2'b01 : 2'b00) << r_bank))
                 | ((set_full ? 2'b01 : 2'b00) << w_bank);
      valid     <= rd_en;
      overflow  <= ovf_n;
      sym_abort <= abort_n;
      if (rd_en) begin
        data_out_i <= mem_i[{rd_bank, rd_addr}];
        data_out_q <= mem_q[{rd_bank, rd_addr}];
      end else begin
        data_out_i <= '0;
        data_out_q <= '0;
      end
    end
  end

endmodule

// File: tb/tb_ofdm_cp_strip.sv
// tb_ofdm_cp_strip
// Directed bench for ofdm_cp_strip. u0 uses the default parameters, u1 a
// small CP-less configuration (NFFT=8, CP_LEN=0); both share the inputs.
module tb_ofdm_cp_strip;

  logic        clk;
  logic        reset;
  logic        valid_in;
  logic        sym_start;
  logic [15:0] data_in_i;
  logic [15:0] data_in_q;
  logic        flag_wayt_data;

  logic        valid0, ovf0, abort0;
  logic [15:0] out_i0, out_q0;
  logic        valid1, ovf1, abort1;
  logic [15:0] out_i1, out_q1;

  int errors = 0;
  int checks = 0;

  int q0_i[$], q0_q[$], runs0[$];
  int q1_i[$], q1_q[$], runs1[$];
  int run0 = 0, run1 = 0;
  int ovf_cnt0 = 0, abort_cnt0 = 0, ovf_cnt1 = 0, abort_cnt1 = 0;

  ofdm_cp_strip u0 (
    .clk(clk), .reset(reset), .valid_in(valid_in), .sym_start(sym_start),
    .data_in_i(data_in_i), .data_in_q(data_in_q), .flag_wayt_data(flag_wayt_data),
    .valid(valid0), .data_out_i(out_i0), .data_out_q(out_q0),
    .overflow(ovf0), .sym_abort(abort0)
  );

  ofdm_cp_strip #(.SIZE_BUFFER(3), .DATA_FFT_SIZE(16), .CP_LEN(0)) u1 (
    .clk(clk), .reset(reset), .valid_in(valid_in), .sym_start(sym_start),
    .data_in_i(data_in_i), .data_in_q(data_in_q), .flag_wayt_data(flag_wayt_data),
    .valid(valid1), .data_out_i(out_i1), .data_out_q(out_q1),
    .overflow(ovf1), .sym_abort(abort1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Output monitors: record every valid sample, the length of each run of
  // valid, and the number of overflow/abort pulse cycles.
  always @(negedge clk) begin
    if (valid0) begin
      q0_i.push_back(int'(out_i0));
      q0_q.push_back(int'(out_q0));
      run0++;
    end else if (run0 > 0) begin
      runs0.push_back(run0);
      run0 = 0;
    end
    if (ovf0)   ovf_cnt0++;
    if (abort0) abort_cnt0++;
  end

  always @(negedge clk) begin
    if (valid1) begin
      q1_i.push_back(int'(out_i1));
      q1_q.push_back(int'(out_q1));
      run1++;
    end else if (run1 > 0) begin
      runs1.push_back(run1);
      run1 = 0;
    end
    if (ovf1)   ovf_cnt1++;
    if (abort1) abort_cnt1++;
  end

  function automatic int qOf(input int v);
    return (v ^ 32'hA5A5) & 32'hFFFF;
  endfunction

  task automatic checkOutput(input string tag, input int observed, input int expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d expected %0d", tag, observed, expected);
    end
  endtask

  task automatic clearMonitors();
    @(posedge clk);
    #1;
    q0_i.delete(); q0_q.delete(); runs0.delete();
    q1_i.delete(); q1_q.delete(); runs1.delete();
    run0 = 0; run1 = 0;
    ovf_cnt0 = 0; abort_cnt0 = 0; ovf_cnt1 = 0; abort_cnt1 = 0;
  endtask

  // One symbol of 'count' contiguous samples valued base, base+1, ... with
  // sym_start on the first. With gap set, every sample is followed by an
  // idle cycle that carries junk data and a stray sym_start.
  task automatic applyStimulus(input int base, input int count, input bit gap);
    for (int k = 0; k < count; k++) begin
      @(negedge clk);
      valid_in  = 1'b1;
      sym_start = (k == 0);
      data_in_i = 16'(base + k);
      data_in_q = 16'(qOf(base + k));
      if (gap) begin
        @(negedge clk);
        valid_in  = 1'b0;
        sym_start = 1'b1;
        data_in_i = 16'hDEAD;
        data_in_q = 16'hBEEF;
      end
    end
    @(negedge clk);
    valid_in  = 1'b0;
    sym_start = 1'b0;
  endtask

  task automatic waitSamples(input bit sel, input int n, input int budget);
    for (int c = 0; c < budget; c++) begin
      @(posedge clk);
      if ((sel ? q1_i.size() : q0_i.size()) >= n) break;
    end
  endtask

  task automatic checkSamples(input string tag, input bit sel, input int base,
                              input int count, input int offset);
    int oi, oq;
    for (int k = 0; k < count; k++) begin
      if (offset + k < (sel ? q1_i.size() : q0_i.size())) begin
        oi = sel ? q1_i[offset + k] : q0_i[offset + k];
        oq = sel ? q1_q[offset + k] : q0_q[offset + k];
        checkOutput($sformatf("%s_i[%0d]", tag, k), oi, base + k);
        checkOutput($sformatf("%s_q[%0d]", tag, k), oq, qOf(base + k));
      end
    end
  endtask

  initial begin
    reset          = 1'b0;
    valid_in       = 1'b0;
    sym_start      = 1'b0;
    data_in_i      = '0;
    data_in_q      = '0;
    flag_wayt_data = 1'b1;

    // Reset state
    repeat (2) @(negedge clk);
    checkOutput("rst_valid", int'(valid0), 0);
    checkOutput("rst_data_i", int'(out_i0), 0);
    checkOutput("rst_data_q", int'(out_q0), 0);
    checkOutput("rst_overflow", int'(ovf0), 0);
    checkOutput("rst_abort", int'(abort0), 0);
    checkOutput("rst_valid_small", int'(valid1), 0);
    reset = 1'b1;

    // Contiguous symbol: CP 0..31 dropped, body 32..287 in one burst
    clearMonitors();
    applyStimulus(0, 288, 1'b0);
    waitSamples(1'b0, 256, 400);
    repeat (5) @(negedge clk);
    checkOutput("t1_count", q0_i.size(), 256);
    checkOutput("t1_runs", runs0.size(), 1);
    checkOutput("t1_runlen", (runs0.size() > 0) ? runs0[0] : 0, 256);
    checkSamples("t1", 1'b0, 32, 256, 0);
    checkOutput("t1_overflow", ovf_cnt0, 0);
    checkOutput("t1_abort", abort_cnt0, 0);

    // Same symbol with valid_in low every other cycle
    clearMonitors();
    applyStimulus(0, 288, 1'b1);
    waitSamples(1'b0, 256, 400);
    repeat (5) @(negedge clk);
    checkOutput("t2_count", q0_i.size(), 256);
    checkOutput("t2_runs", runs0.size(), 1);
    checkOutput("t2_runlen", (runs0.size() > 0) ? runs0[0] : 0, 256);
    checkSamples("t2", 1'b0, 32, 256, 0);
    checkOutput("t2_overflow", ovf_cnt0, 0);
    checkOutput("t2_abort", abort_cnt0, 0);

    // FFT not ready: two symbols buffered, the third overflows
    flag_wayt_data = 1'b0;
    clearMonitors();
    applyStimulus(2000, 288, 1'b0);
    applyStimulus(3000, 288, 1'b0);
    applyStimulus(4000, 288, 1'b0);
    repeat (20) @(negedge clk);
    checkOutput("t3_held", q0_i.size(), 0);
    checkOutput("t3_overflow", ovf_cnt0, 1);
    flag_wayt_data = 1'b1;
    waitSamples(1'b0, 512, 1200);
    repeat (5) @(negedge clk);
    checkOutput("t3_count", q0_i.size(), 512);
    checkSamples("t3_sym1", 1'b0, 2032, 256, 0);
    checkSamples("t3_sym2", 1'b0, 3032, 256, 256);
    checkOutput("t3_overflow_after", ovf_cnt0, 1);
    checkOutput("t3_abort", abort_cnt0, 0);

    // sym_start at body sample 100 discards the partial symbol
    clearMonitors();
    applyStimulus(5000, 132, 1'b0);
    applyStimulus(6000, 288, 1'b0);
    waitSamples(1'b0, 256, 400);
    repeat (5) @(negedge clk);
    checkOutput("t4_count", q0_i.size(), 256);
    checkSamples("t4", 1'b0, 6032, 256, 0);
    checkOutput("t4_abort", abort_cnt0, 1);
    checkOutput("t4_overflow", ovf_cnt0, 0);

    // Reset in the middle of a burst
    clearMonitors();
    applyStimulus(7000, 288, 1'b0);
    waitSamples(1'b0, 50, 400);
    @(negedge clk);
    checkOutput("t6_pre_valid", int'(valid0), 1);
    reset = 1'b0;
    #1;
    checkOutput("t6_valid_drop", int'(valid0), 0);
    checkOutput("t6_data_zero", int'(out_i0), 0);
    repeat (3) @(negedge clk);
    reset = 1'b1;
    clearMonitors();
    repeat (400) @(negedge clk);
    checkOutput("t6_no_stale", q0_i.size(), 0);
    applyStimulus(8000, 288, 1'b0);
    waitSamples(1'b0, 256, 400);
    repeat (5) @(negedge clk);
    checkOutput("t6_count", q0_i.size(), 256);
    checkSamples("t6", 1'b0, 8032, 256, 0);

    // Small instance, no CP: 8 samples straight through
    clearMonitors();
    applyStimulus(5, 8, 1'b0);
    waitSamples(1'b1, 8, 100);
    repeat (5) @(negedge clk);
    checkOutput("t5_count", q1_i.size(), 8);
    checkOutput("t5_runs", runs1.size(), 1);
    checkOutput("t5_runlen", (runs1.size() > 0) ? runs1[0] : 0, 8);
    checkSamples("t5", 1'b1, 5, 8, 0);
    checkOutput("t5_overflow", ovf_cnt1, 0);
    checkOutput("t5_abort", abort_cnt1, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/ofdm_cp_strip.md
OFDM_CP_STRIP -- requirements
Module: ofdm_cp_strip

Interface
REQ-001 SHALL have parameter SIZE_BUFFER, default 8, meaning log2(NFFT) with NFFT = 2**SIZE_BUFFER samples per symbol body.
REQ-002 SHALL have parameter DATA_FFT_SIZE, default 16, meaning I/Q sample width in two's complement.
REQ-003 SHALL have parameter CP_LEN, default 32, meaning cyclic-prefix samples discarded per symbol; legal range 0..NFFT-1.
REQ-004 SHALL have port clk, input, 1, the single clock; all logic is on its rising edge.
REQ-005 SHALL have port reset, input, 1, asynchronous active-low reset (0 = reset).
REQ-006 SHALL have port valid_in, input, 1, input sample qualifier.
REQ-007 SHALL have port sym_start, input, 1, marks the first sample of a symbol (first CP sample); meaningful only with valid_in=1.
REQ-008 SHALL have ports data_in_i and data_in_q, input, DATA_FFT_SIZE, input sample.
REQ-009 SHALL have port flag_wayt_data, input, 1, downstream FFT ready to accept a new NFFT burst.
REQ-010 SHALL have port valid, output, 1, burst valid to FFT (drives FFT valid).
REQ-011 SHALL have ports data_out_i and data_out_q, output, DATA_FFT_SIZE, symbol-body sample to FFT.
REQ-012 SHALL have port overflow, output, 1, one-cycle pulse when a whole symbol is dropped for lack of a buffer bank.
REQ-013 SHALL have port sym_abort, output, 1, one-cycle pulse when a partially received symbol is discarded.

Function
REQ-014 SHALL contain two buffer banks of NFFT I/Q entries each, with a full flag per bank; banks are filled and read in strict alternation, oldest full bank read first.
REQ-015 Write FSM SHALL have states W_IDLE, W_CP, W_BODY; valid_in=0 cycles SHALL be ignored by all write states (no counting, no writing).
REQ-016 In W_IDLE, valid_in=1 with sym_start=1 and a free bank SHALL enter W_CP with the sample counted as CP sample 1; with CP_LEN=0 it SHALL enter W_BODY with the sample written as body sample 0.
REQ-017 In W_CP, after CP_LEN accepted samples (including the start sample) the FSM SHALL enter W_BODY; CP samples SHALL never be written.
REQ-018 In W_BODY, accepted samples SHALL be written at addresses 0..NFFT-1; the write of address NFFT-1 SHALL set the bank full flag, toggle the write bank, and return to W_IDLE.
REQ-019 A sample with sym_start=1 received in W_CP or W_BODY SHALL discard the partial symbol, pulse sym_abort, and restart per REQ-016 with that sample.
REQ-020 sym_start=1 when no bank is free SHALL pulse overflow and stay in W_IDLE, ignoring samples until the next sym_start.
REQ-021 sym_start=1 arriving while in W_IDLE with sym_start=0 samples preceding it: those non-start samples in W_IDLE SHALL be discarded silently.
REQ-022 Read FSM SHALL have states R_IDLE and R_BURST; in R_IDLE at an edge where the read bank is full and flag_wayt_data=1 it SHALL enter R_BURST and issue read address 0.
REQ-023 In R_BURST the read address SHALL increment every cycle regardless of flag_wayt_data; valid SHALL be 1 for exactly NFFT consecutive cycles, first valid cycle one cycle after R_BURST entry (registered RAM read).
REQ-024 data_out_i/q SHALL equal body samples 0..NFFT-1 in order while valid=1 and SHALL be 0 while valid=0.
REQ-025 On the edge issuing address NFFT-1, the bank full flag SHALL clear and the read bank toggle; a bank freed at the same edge as a sym_start requests it SHALL be treated as free.
REQ-026 A second burst MAY start the cycle after the previous burst's last valid (back-to-back bursts allowed).
REQ-027 No arithmetic on samples SHALL be performed; data passes bit-exact.

Reset
REQ-028 reset=0 SHALL asynchronously force valid=0, data_out_i/q=0, overflow=0, sym_abort=0, both full flags=0, both FSMs to idle, bank pointers to bank 0, counters to 0, even mid-burst or mid-symbol.
REQ-029 Buffer RAM contents SHALL NOT require reset; stale contents SHALL never be output.

Verification
REQ-030 Defaults, flag_wayt_data=1, 288 contiguous samples data_in_i=n (0..287), sym_start at n=0 -> valid high 256 consecutive cycles, data_out_i=32..287, overflow=0, sym_abort=0.
REQ-031 Same stimulus with valid_in toggling every other cycle -> identical output sequence 32..287 in one contiguous 256-cycle burst.
REQ-032 flag_wayt_data=0, three back-to-back symbols -> symbols 1,2 buffered, overflow pulses once at symbol 3 sym_start; raise flag_wayt_data -> two 256-cycle bursts of symbols 1 then 2.
REQ-033 sym_start reasserted at body sample 100 of symbol 1 -> sym_abort one pulse, only the restarted symbol is output.
REQ-034 CP_LEN=0, SIZE_BUFFER=3, 8 samples 5..12 -> valid 8 cycles, data_out_i=5..12.
REQ-035 reset=0 at burst cycle 50 -> valid drops to 0 immediately; after release no output until a new full symbol arrives.
